mc_exec_unit: RTL and testbench
===============================

// Module: mc_exec_unit
// PURPOSE
//  Parametrised execute slice for the multi-cycle CPU: accumulator bank, latched A/B operands,
//  ALU, result register and CZN flag register, sequenced by an internal FSM behind a start/done
//  handshake. Adds iterative shift and shift-add multiply.
//  The control unit issues one op at a time.
//  The memory path loads/stores accumulators through the ext ports.
// PARAMETERS
//  DATA_W   8  datapath width (>=4)
//  NUM_ACC  4  accumulator count (power of 2); AW = $clog2(NUM_ACC)
//  MUL_EN   1  1: MUL implemented; 0: MUL behaves as NOP (no write, flags kept)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  start        in   1       issue request; sampled only in IDLE
//  op           in   3       000 ADD, 001 ADC, 010 SUB, 011 AND, 100 OR, 101 NOT A, 110 SHL, 111 MUL
//  src_a_sel    in   AW      A operand accumulator
//  src_b_sel    in   AW      B operand accumulator
//  use_imm      in   1       1: B operand = imm
//  imm          in   DATA_W  immediate B operand
//  dst_sel      in   AW      destination accumulator
//  busy         out  1       high in any state other than IDLE
//  done         out  1       registered, one-cycle pulse in WB
//  result       out  DATA_W  last written-back value, held
//  czn          out  3       [2]=C [1]=Z [0]=N, held between ops
//  ext_we       in   1       external load into accumulator
//  ext_waddr    in   AW      external load address
//  ext_wdata    in   DATA_W  external load data
//  ext_raddr    in   AW      external read address
//  ext_rdata    out  DATA_W  combinational read of acc[ext_raddr]
// BEHAVIOUR
//  - Reset (rst=0, async): FSM to IDLE; all accumulators, operand regs, result, czn and done to 0.
//    An op in flight is abandoned: no write-back, no done.
//  - FSM states: IDLE, EXEC, WB.
//    IDLE: on start=1, latch A=acc[src_a_sel], B=use_imm?imm:acc[src_b_sel], op, dst; go to EXEC.
//    EXEC, single-cycle ops: compute into the result reg; go to WB after 1 cycle.
//    EXEC, SHL: shift left by B[$clog2(DATA_W)-1:0], one bit per cycle, minimum 1 cycle.
//    EXEC, MUL: shift-add multiply over exactly DATA_W cycles; keep the low DATA_W bits.
//    WB: write acc[dst], update czn, done=1; go to IDLE.
//  - Latency from the edge sampling start to the edge raising done = N_exec+2 cycles.
//    Simple ops: 3. SHL: max(k,1)+2. MUL: DATA_W+2.
//  - start while busy is ignored; there is no queueing. Back-to-back ops: start may be high in the
//    cycle after done.
//  - Operands are latched: ext writes or WB to a source accumulator after the issue edge do not
//    affect the op in flight. src == dst is legal.
//  - Flags, written at WB only:
//    C = carry-out (ADD/ADC), borrow (SUB, 1 when A<B unsigned), 0 (AND/OR/NOT),
//    last bit shifted out (SHL; 0 if k=0), OR of the product high half (MUL).
//    Z = (result == 0). N = result[DATA_W-1].
//  - ADC uses the C value held in czn at the issue edge.
//  - ext_we is honoured in any state. If ext_we and WB target the same accumulator in the same
//    cycle, the WB value wins. Different addresses: both writes happen.
//  - Arithmetic is unsigned modulo 2^DATA_W; no overflow flag.
// STRUCTURE
//  - Package mc_exec_pkg: op-code localparams, FSM state encoding, CZN bit indices.
//  - Sub-module mc_acc_bank: NUM_ACC x DATA_W bank with async active-low clear, two comb read
//    ports (A/B), one comb ext read port, and two write ports with fixed priority (WB over ext).
//  - ALU and iterative shift/multiply sequencing stay in mc_exec_unit.
// TESTING (DATA_W=8, NUM_ACC=4)
//  1. ext-load acc0=F0, acc1=20; ADD dst2 -> done 3 cycles after issue; acc2=10, czn=100.
//     ADC same operands -> acc2=11.
//  2. SUB acc1-acc0 -> 30, czn=100. SUB acc1-acc1 -> 00, czn=010.
//     NOT acc0 -> 0F, czn=000.
//  3. MUL 13*11 -> acc=43, czn=100, done 10 cycles after issue, busy high throughout.
//     MUL_EN=0 -> no write, czn unchanged.
//  4. SHL 81 by imm 1 -> 02, czn=100, latency 3. SHL 81 by 0 -> 81, czn=001, latency 3.
//     SHL 01 by 7 -> 80, czn=001, latency 9.
//  5. Hazards: start pulse during EXEC is ignored (one done only).
//     ext write to src during EXEC leaves result unchanged.
//     ext write 55 and WB AA to the same acc in one cycle -> acc=AA.
//  6. Reset mid-MUL: rst low for 1 cycle at EXEC cycle 4 -> busy=0, done never pulses,
//     czn=000, all ext_rdata=00; the next ADD issued completes normally.

Source files
------------

// File: rtl/mc_exec_pkg.sv
// Shared definitions for the multi-cycle execute slice: op codes, FSM states
// and bit positions inside the CZN flag vector.
package mc_exec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam int CZN_C = 2;
    localparam int CZN_Z = 1;
    localparam int CZN_N = 0;

endpackage

// File: rtl/mc_acc_bank.sv
// Accumulator bank: two operand read ports, one external read port, and two
// write ports where write-back takes priority over the external load path.
module mc_acc_bank #(
    parameter int  DATA_W  = 8,
    parameter int  NUM_ACC = 4,
    localparam int AW      = $clog2(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     rx_addr,
    output logic [DATA_W-1:0] rx_data,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DATA_W-1:0] ext_data
);

    logic [NUM_ACC-1:0][DATA_W-1:0] mem_q, mem_d;

    // Write-back is applied last so it overrides an external load to the same entry.
    always_comb begin
        mem_d = mem_q;
        if (ext_we) mem_d[ext_addr] = ext_data;
        if (wb_we)  mem_d[wb_addr]  = wb_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '0;
        else      mem_q <= mem_d;
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];
    assign rx_data = mem_q[rx_addr];

endmodule

// File: rtl/mc_exec_unit.sv
// Multi-cycle execute slice: latches operands on issue, runs the ALU or an
// iterative shift / shift-add multiply, then writes back result and CZN flags.
module mc_exec_unit
    import mc_exec_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NUM_ACC = 4,
    parameter bit  MUL_EN  = 1'b1,
    localparam int AW      = $clog2(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [AW-1:0]     src_a_sel,
    input  logic [AW-1:0]     src_b_sel,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [AW-1:0]     dst_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        czn,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_waddr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [AW-1:0]     ext_raddr,
    output logic [DATA_W-1:0] ext_rdata
);

    localparam int SW = $clog2(DATA_W);
    localparam int CW = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic                first_q, first_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [AW-1:0]       dst_q, dst_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                cin_q, cin_d;
    logic [2*DATA_W-1:0] work_q, work_d, mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [2:0]          czn_q, czn_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   rd_a, rd_b, wb_val, alu_res;
    logic [DATA_W:0]     alu_sum;
    logic [SW-1:0]       shamt;
    logic                alu_c, wb_we, is_nop, wb_c;

    mc_acc_bank #(.DATA_W(DATA_W), .NUM_ACC(NUM_ACC)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (src_a_sel),
        .ra_data (rd_a),
        .rb_addr (src_b_sel),
        .rb_data (rd_b),
        .rx_addr (ext_raddr),
        .rx_data (ext_rdata),
        .wb_we   (wb_we),
        .wb_addr (dst_q),
        .wb_data (wb_val),
        .ext_we  (ext_we),
        .ext_addr(ext_waddr),
        .ext_data(ext_wdata)
    );

    assign shamt  = b_q[SW-1:0];
    assign is_nop = (op_q == OP_MUL) && !MUL_EN;
    assign wb_val = work_q[DATA_W-1:0];
    // MUL carry reports any set bit of the discarded high half.
    assign wb_c   = (op_q == OP_MUL) ? |work_q[2*DATA_W-1:DATA_W] : c_q;

    // Bit DATA_W of the extended sum is carry-out for adds and borrow for SUB.
    always_comb begin
        alu_sum = '0;
        case (op_q)
            OP_ADD:  alu_sum = {1'b0, a_q} + {1'b0, b_q};
            OP_ADC:  alu_sum = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, cin_q};
            OP_SUB:  alu_sum = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_sum = {1'b0, a_q & b_q};
            OP_OR:   alu_sum = {1'b0, a_q | b_q};
            OP_NOT:  alu_sum = {1'b0, ~a_q};
            default: alu_sum = '0;
        endcase
        alu_res = alu_sum[DATA_W-1:0];
        alu_c   = alu_sum[DATA_W];
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dst_d    = dst_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        c_d      = c_q;
        result_d = result_q;
        czn_d    = czn_q;
        done_d   = 1'b0;
        wb_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = rd_a;
                    b_d     = use_imm ? imm : rd_b;
                    op_d    = op;
                    dst_d   = dst_sel;
                    cin_d   = czn_q[CZN_C];
                    first_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (first_q) begin
                    // Setup cycle: load the iteration count and working registers.
                    first_d  = 1'b0;
                    c_d      = 1'b0;
                    mcand_d  = {{DATA_W{1'b0}}, a_q};
                    mplier_d = b_q;
                    work_d   = (op_q == OP_MUL) ? '0 : {{DATA_W{1'b0}}, a_q};
                    if (op_q == OP_SHL && shamt != '0)  cnt_d = CW'(shamt);
                    else if (op_q == OP_MUL && MUL_EN) cnt_d = CW'(DATA_W);
                    else                               cnt_d = CW'(1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = ST_WB;
                    case (op_q)
                        OP_SHL: begin
                            if (shamt != '0) begin
                                c_d    = work_q[DATA_W-1];
                                work_d = {{DATA_W{1'b0}}, work_q[DATA_W-2:0], 1'b0};
                            end
                        end
                        OP_MUL: begin
                            if (mplier_q[0]) work_d = work_q + mcand_q;
                            mcand_d  = mcand_q << 1;
                            mplier_d = mplier_q >> 1;
                        end
                        default: begin
                            work_d = {{DATA_W{1'b0}}, alu_res};
                            c_d    = alu_c;
                        end
                    endcase
                end
            end
            ST_WB: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (!is_nop) begin
                    wb_we        = 1'b1;
                    result_d     = wb_val;
                    czn_d[CZN_C] = wb_c;
                    czn_d[CZN_Z] = (wb_val == '0);
                    czn_d[CZN_N] = wb_val[DATA_W-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            work_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            czn_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            c_q      <= c_d;
            result_q <= result_d;
            czn_q    <= czn_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign czn    = czn_q;

endmodule

// File: tb/tb_mc_exec_unit.sv
// Scoreboard bench for mc_exec_unit: a MUL-enabled and a MUL-disabled instance
// share stimulus; expectations are queued on issue and popped on done.
module tb_mc_exec_unit;
    import mc_exec_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, start_nm, use_imm, ext_we;
    logic [2:0] op;
    logic [1:0] src_a_sel, src_b_sel, dst_sel, ext_waddr, ext_raddr;
    logic [7:0] imm, ext_wdata;
    logic       busy, done, busy_nm, done_nm;
    logic [7:0] result, ext_rdata, result_nm, ext_rdata_nm;
    logic [2:0] czn, czn_nm;

    typedef struct packed {
        logic [2:0] op; logic [1:0] sa; logic [1:0] sb; logic ui; logic [7:0] imm; logic [1:0] dst;
    } req_t;
    typedef struct packed { logic [7:0] res; logic [2:0] czn; int lat; } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mc_exec_unit #(.DATA_W(8), .NUM_ACC(4), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .use_imm(use_imm), .imm(imm), .dst_sel(dst_sel), .busy(busy), .done(done), .result(result),
        .czn(czn), .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .ext_raddr(ext_raddr), .ext_rdata(ext_rdata)
    );

    mc_exec_unit #(.DATA_W(8), .NUM_ACC(4), .MUL_EN(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .start(start_nm), .op(op), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .use_imm(use_imm), .imm(imm), .dst_sel(dst_sel), .busy(busy_nm), .done(done_nm),
        .result(result_nm), .czn(czn_nm), .ext_we(ext_we), .ext_waddr(ext_waddr),
        .ext_wdata(ext_wdata), .ext_raddr(ext_raddr), .ext_rdata(ext_rdata_nm)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ext_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        @(posedge clk);
        #1 ext_we = 1'b0;
    endtask

    // Issue one op and count edges after the issue edge until done is seen (bounded).
    task automatic run_op(input req_t r, input bit nm, output int lat, output int busy_drop, output bit ok);
        @(negedge clk);
        op = r.op; src_a_sel = r.sa; src_b_sel = r.sb; use_imm = r.ui; imm = r.imm; dst_sel = r.dst;
        if (nm) start_nm = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; start_nm = 1'b0;
        lat = 0; busy_drop = 0; ok = 1'b0;
        while (!ok && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (nm ? done_nm : done) ok = 1'b1;
            else if (!(nm ? busy_nm : busy)) busy_drop++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start_nm = 1'b0; op = '0; src_a_sel = '0; src_b_sel = '0;
        use_imm = 1'b0; imm = '0; dst_sel = '0; ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0;
        ext_raddr = '0;
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset result: got %h want 00", result); end
        n_checks++; if (czn !== 3'b000) begin n_fail++; $display("FAIL reset czn: got %b want 000", czn); end
        for (int a = 0; a < 4; a++) begin
            ext_raddr = 2'(a); #1;
            n_checks++; if (ext_rdata !== 8'h00) begin n_fail++; $display("FAIL reset acc%0d: got %h want 00", a, ext_rdata); end
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_add_adc();
        req_t rq[2]; exp_t ex[2]; exp_t e; int lat, bd; bit ok;
        ext_write(2'd0, 8'hF0); ext_write(2'd1, 8'h20);
        rq[0] = '{OP_ADD, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2}; ex[0] = '{8'h10, 3'b100, 3};
        rq[1] = '{OP_ADC, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2}; ex[1] = '{8'h11, 3'b100, 3};
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(ex[i]);
            run_op(rq[i], 1'b0, lat, bd, ok);
            e = sb_q.pop_front();
            n_checks++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL add_adc[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL add_adc[%0d] result: got %h want %h", i, result, e.res); end
            n_checks++; if (czn !== e.czn) begin n_fail++; $display("FAIL add_adc[%0d] czn: got %b want %b", i, czn, e.czn); end
            ext_raddr = rq[i].dst; #1;
            n_checks++; if (ext_rdata !== e.res) begin n_fail++; $display("FAIL add_adc[%0d] acc: got %h want %h", i, ext_rdata, e.res); end
        end
    endtask

    task automatic test_sub_not();
        req_t rq[3]; exp_t ex[3]; exp_t e; int lat, bd; bit ok;
        rq[0] = '{OP_SUB, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2}; ex[0] = '{8'h30, 3'b100, 3};
        rq[1] = '{OP_SUB, 2'd1, 2'd1, 1'b0, 8'h00, 2'd3}; ex[1] = '{8'h00, 3'b010, 3};
        rq[2] = '{OP_NOT, 2'd0, 2'd0, 1'b0, 8'h00, 2'd2}; ex[2] = '{8'h0F, 3'b000, 3};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(ex[i]);
            run_op(rq[i], 1'b0, lat, bd, ok);
            e = sb_q.pop_front();
            n_checks++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL sub_not[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL sub_not[%0d] result: got %h want %h", i, result, e.res); end
            n_checks++; if (czn !== e.czn) begin n_fail++; $display("FAIL sub_not[%0d] czn: got %b want %b", i, czn, e.czn); end
            ext_raddr = rq[i].dst; #1;
            n_checks++; if (ext_rdata !== e.res) begin n_fail++; $display("FAIL sub_not[%0d] acc: got %h want %h", i, ext_rdata, e.res); end
        end
    endtask

    task automatic test_mul();
        req_t r; exp_t e; int lat, bd; bit ok;
        ext_write(2'd0, 8'h13); ext_write(2'd1, 8'h11);
        r = '{OP_MUL, 2'd0, 2'd1, 1'b0, 8'h00, 2'd3};
        sb_q.push_back('{8'h43, 3'b100, 10});
        run_op(r, 1'b0, lat, bd, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL mul latency: got %0d want %0d", lat, e.lat); end
        n_checks++; if (bd != 0) begin n_fail++; $display("FAIL mul busy: dropped %0d cycles want 0", bd); end
        n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL mul result: got %h want %h", result, e.res); end
        n_checks++; if (czn !== e.czn) begin n_fail++; $display("FAIL mul czn: got %b want %b", czn, e.czn); end
        ext_raddr = 2'd3; #1;
        n_checks++; if (ext_rdata !== e.res) begin n_fail++; $display("FAIL mul acc: got %h want %h", ext_rdata, e.res); end
        // MUL-disabled instance: set flags with a SUB, then MUL must leave everything alone.
        r = '{OP_SUB, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2};
        sb_q.push_back('{8'hFE, 3'b101, 3});
        run_op(r, 1'b1, lat, bd, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || lat != e.lat || czn_nm !== e.czn) begin n_fail++; $display("FAIL nomul sub: lat %0d czn %b want lat %0d czn %b", lat, czn_nm, e.lat, e.czn); end
        r = '{OP_MUL, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2};
        sb_q.push_back('{8'hFE, 3'b101, 3});
        run_op(r, 1'b1, lat, bd, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL nomul mul latency: got %0d want %0d", lat, e.lat); end
        n_checks++; if (czn_nm !== e.czn) begin n_fail++; $display("FAIL nomul mul czn: got %b want %b", czn_nm, e.czn); end
        n_checks++; if (result_nm !== e.res) begin n_fail++; $display("FAIL nomul mul result: got %h want %h", result_nm, e.res); end
        ext_raddr = 2'd2; #1;
        n_checks++; if (ext_rdata_nm !== e.res) begin n_fail++; $display("FAIL nomul mul acc: got %h want %h", ext_rdata_nm, e.res); end
    endtask

    task automatic test_shl();
        req_t rq[3]; exp_t ex[3]; logic [7:0] pre[3]; exp_t e; int lat, bd; bit ok;
        pre[0] = 8'h81; rq[0] = '{OP_SHL, 2'd0, 2'd0, 1'b1, 8'h01, 2'd1}; ex[0] = '{8'h02, 3'b100, 3};
        pre[1] = 8'h81; rq[1] = '{OP_SHL, 2'd0, 2'd0, 1'b1, 8'h00, 2'd1}; ex[1] = '{8'h81, 3'b001, 3};
        pre[2] = 8'h01; rq[2] = '{OP_SHL, 2'd0, 2'd0, 1'b1, 8'h07, 2'd1}; ex[2] = '{8'h80, 3'b001, 9};
        for (int i = 0; i < 3; i++) begin
            ext_write(2'd0, pre[i]);
            sb_q.push_back(ex[i]);
            run_op(rq[i], 1'b0, lat, bd, ok);
            e = sb_q.pop_front();
            n_checks++; if (!ok || lat != e.lat) begin n_fail++; $display("FAIL shl[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (result !== e.res) begin n_fail++; $display("FAIL shl[%0d] result: got %h want %h", i, result, e.res); end
            n_checks++; if (czn !== e.czn) begin n_fail++; $display("FAIL shl[%0d] czn: got %b want %b", i, czn, e.czn); end
            ext_raddr = rq[i].dst; #1;
            n_checks++; if (ext_rdata !== e.res) begin n_fail++; $display("FAIL shl[%0d] acc: got %h want %h", i, ext_rdata, e.res); end
        end
    endtask

    task automatic test_hazards();
        exp_t e; int dones, lat;
        // Extra start pulses during a MUL must be ignored.
        ext_write(2'd0, 8'h13); ext_write(2'd1, 8'h11);
        @(negedge clk);
        op = OP_MUL; src_a_sel = 2'd0; src_b_sel = 2'd1; use_imm = 1'b0; dst_sel = 2'd3; start = 1'b1;
        sb_q.push_back('{8'h43, 3'b100, 10});
        @(posedge clk); #1 start = 1'b0;
        dones = 0; lat = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = (c == 3 || c == 4); op = (c == 3 || c == 4) ? OP_ADD : OP_MUL;
            dst_sel = (c == 3 || c == 4) ? 2'd0 : 2'd3;
            @(posedge clk); #1;
            if (done) begin dones++; if (lat == 0) lat = c; end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL hazard_start dones: got %0d want 1", dones); end
        n_checks++; if (lat != e.lat || result !== e.res) begin n_fail++; $display("FAIL hazard_start op: lat %0d res %h want lat %0d res %h", lat, result, e.lat, e.res); end
        ext_raddr = 2'd0; #1;
        n_checks++; if (ext_rdata !== 8'h13) begin n_fail++; $display("FAIL hazard_start acc0: got %h want 13", ext_rdata); end
        // Source overwritten after issue: operand latch must hold.
        ext_write(2'd0, 8'h05); ext_write(2'd1, 8'h03);
        @(negedge clk);
        op = OP_ADD; src_a_sel = 2'd0; src_b_sel = 2'd1; dst_sel = 2'd2; start = 1'b1;
        sb_q.push_back('{8'h08, 3'b000, 3});
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ext_we = (c == 1); ext_waddr = 2'd0; ext_wdata = 8'hFF;
            @(posedge clk); #1;
            if (done && lat == 0) lat = c;
        end
        ext_we = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (lat != e.lat || result !== e.res || czn !== e.czn) begin n_fail++; $display("FAIL hazard_latch: lat %0d res %h czn %b want %0d %h %b", lat, result, czn, e.lat, e.res, e.czn); end
        // Same-cycle ext write and write-back: same address -> WB wins; different -> both land.
        ext_write(2'd0, 8'hA0); ext_write(2'd1, 8'h0A);
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            op = OP_OR; src_a_sel = 2'd0; src_b_sel = 2'd1; dst_sel = 2'd3; start = 1'b1;
            sb_q.push_back('{8'hAA, 3'b001, 3});
            @(posedge clk); #1 start = 1'b0;
            lat = 0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                ext_we = (c == 3); ext_waddr = (v == 0) ? 2'd3 : 2'd2; ext_wdata = (v == 0) ? 8'h55 : 8'h5A;
                @(posedge clk); #1;
                if (done && lat == 0) lat = c;
            end
            ext_we = 1'b0;
            e = sb_q.pop_front();
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL hazard_wr[%0d] latency: got %0d want %0d", v, lat, e.lat); end
            ext_raddr = 2'd3; #1;
            n_checks++; if (ext_rdata !== e.res) begin n_fail++; $display("FAIL hazard_wr[%0d] acc3: got %h want %h", v, ext_rdata, e.res); end
            if (v == 1) begin
                ext_raddr = 2'd2; #1;
                n_checks++; if (ext_rdata !== 8'h5A) begin n_fail++; $display("FAIL hazard_wr[1] acc2: got %h want 5a", ext_rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        req_t r; exp_t e; int lat, bd; bit ok, seen;
        ext_write(2'd0, 8'h13); ext_write(2'd1, 8'h11);
        @(negedge clk);
        op = OP_MUL; src_a_sel = 2'd0; src_b_sel = 2'd1; use_imm = 1'b0; dst_sel = 2'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mul busy: got %b want 0", busy); end
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mul done: pulsed, want none"); end
        n_checks++; if (czn !== 3'b000 || result !== 8'h00) begin n_fail++; $display("FAIL rst_mul state: czn %b result %h want 000 00", czn, result); end
        for (int a = 0; a < 4; a++) begin
            ext_raddr = 2'(a); #1;
            n_checks++; if (ext_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_mul acc%0d: got %h want 00", a, ext_rdata); end
        end
        ext_write(2'd0, 8'h07); ext_write(2'd1, 8'h09);
        r = '{OP_ADD, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2};
        sb_q.push_back('{8'h10, 3'b000, 3});
        run_op(r, 1'b0, lat, bd, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || lat != e.lat || result !== e.res || czn !== e.czn) begin n_fail++; $display("FAIL rst_mul add: lat %0d res %h czn %b want %0d %h %b", lat, result, czn, e.lat, e.res, e.czn); end
    endtask

    initial begin
        test_reset();
        test_add_adc();
        test_sub_not();
        test_mul();
        test_shl();
        test_hazards();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
